// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory access controller.
// Provides funct3 encodings, FSM state and access-size helpers.
package mem_pkg;

  localparam int WORD_BITWIDTH    = 32;
  localparam int ACK_TIMEOUT_DEF  = 16;
  localparam int TMO_BITWIDTH_DEF = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unsigned byte/half encodings only exist for loads; stores fall back to word.
  function automatic size_t acc_size(
    input logic [2:0] f3,
    input logic       st
  );
    size_t s;
    s = SZ_W;
    if (f3 == F3_B || (!st && f3 == F3_BU))
      s = SZ_B;
    else if (f3 == F3_H || (!st && f3 == F3_HU))
      s = SZ_H;
    return s;
  endfunction

  function automatic logic is_misaligned(
    input size_t      s,
    input logic [1:0] lo
  );
    return (s == SZ_H && lo[0]) ||
           (s == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Single-port data memory bus between the access controller and memory.
// Request/ack handshake; read data is valid in the ack cycle.
interface mem_access_ctrl_if;

  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memBe;
  logic        memAck;
  logic [31:0] memRData;

  modport master (
    output memReq,
    output memWe,
    output memAddr,
    output memWData,
    output memBe,
    input  memAck,
    input  memRData
  );

  modport slave (
    input  memReq,
    input  memWe,
    input  memAddr,
    input  memWData,
    input  memBe,
    output memAck,
    output memRData
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
// Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_lo,
  input  logic        st_we,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  size_t       ssz;
  size_t       lsz;
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  assign ssz = acc_size(st_f3, 1'b1);
  assign lsz = acc_size(ld_f3, 1'b0);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    if (st_we) begin
      unique case (1'b1)
        ssz == SZ_B: begin
          st_be    = 4'b0001 << st_lo;
          st_wdata = {4{st_data[7:0]}};
        end
        ssz == SZ_H: begin
          st_be    = st_lo[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{st_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    b       = 8'(ld_rdata >> {ld_lo, 3'b000});
    h       = ld_lo[1] ? ld_rdata[31:16]
                       : ld_rdata[15:0];
    sx      = ~ld_f3[2];
    ld_data = ld_rdata;
    unique case (1'b1)
      lsz == SZ_B:
        ld_data = {{24{sx & b[7]}}, b};
      lsz == SZ_H:
        ld_data = {{16{sx & h[15]}}, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer onto a req/ack single-port data memory.
// Stalls the pipeline while an access is outstanding.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32,
  parameter int ACK_TIMEOUT   = 16,
  parameter int TMO_BITWIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] ALUresult,
  input  logic [WORD_BITWIDTH-1:0] readData2,
  output logic                     stall,
  output logic [WORD_BITWIDTH-1:0] loadData,
  output logic                     loadValid,
  output logic                     misaligned,
  output logic                     busError,
  mem_access_ctrl_if.master        bus
);

  localparam logic [TMO_BITWIDTH-1:0] TMO_LAST =
    TMO_BITWIDTH'(ACK_TIMEOUT - 1);

  state_t                  state;
  logic [TMO_BITWIDTH-1:0] tmo;
  logic [2:0]              f3_q;
  logic [1:0]              lo_q;

  logic        access;
  logic        bad;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] ld_ext;

  assign access = memRead | memWrite;
  assign bad    = is_misaligned(acc_size(funct3, memWrite),
                                ALUresult[1:0]);

  // Gated by rst_n so the stall releases the instant reset asserts.
  assign stall = rst_n &
                 ((state == IDLE && access && !bad) ||
                  state == REQ);

  mem_lane_align u_lane (
    .st_f3    (funct3),
    .st_lo    (ALUresult[1:0]),
    .st_we    (memWrite),
    .st_data  (readData2),
    .st_be    (be_n),
    .st_wdata (wd_n),
    .ld_f3    (f3_q),
    .ld_lo    (lo_q),
    .ld_rdata (bus.memRData),
    .ld_data  (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmo          <= '0;
      f3_q         <= '0;
      lo_q         <= '0;
      bus.memReq   <= 1'b0;
      bus.memWe    <= 1'b0;
      bus.memAddr  <= '0;
      bus.memWData <= '0;
      bus.memBe    <= '0;
      loadData     <= '0;
      loadValid    <= 1'b0;
      misaligned   <= 1'b0;
      busError     <= 1'b0;
    end else begin
      loadValid  <= 1'b0;
      misaligned <= 1'b0;
      busError   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access && bad) begin
            misaligned <= 1'b1;
          end else if (access) begin
            bus.memReq   <= 1'b1;
            bus.memWe    <= memWrite;
            bus.memAddr  <= {ALUresult[31:2], 2'b00};
            bus.memBe    <= be_n;
            bus.memWData <= wd_n;
            f3_q         <= funct3;
            lo_q         <= ALUresult[1:0];
            tmo          <= '0;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.memAck) begin
            bus.memReq <= 1'b0;
            if (!bus.memWe) begin
              loadData  <= ld_ext;
              loadValid <= 1'b1;
            end
            state <= DONE;
          end else if (tmo == TMO_LAST) begin
            bus.memReq <= 1'b0;
            busError   <= 1'b1;
            loadData   <= '0;
            state      <= DONE;
          end else begin
            tmo <= tmo + TMO_BITWIDTH'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
